// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl_if
// Description : Request/response bundle between the LSU (master) and the
//               data memory controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned,
               req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned,
               req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Byte-addressable data memory for the load/store stage.
//               Valid/ready requests, held responses, byte/half/word
//               accesses with sign/zero extension, word-crossing accesses
//               split into two beats, out-of-range error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DEPTH_BYTES      = 1024,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    data_mem_ctrl_if.slave  bus
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WW    = AW - 2;
    localparam int WORDS = DEPTH_BYTES / 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state;
    logic        ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    // Storage is word-organised with per-byte write enables.
    logic [31:0] mem [WORDS];

    // Request fields captured at accept for the second beat.
    logic [WW-1:0] hi_idx;
    logic [3:0]    hi_be;
    logic [31:0]   hi_wdata;
    logic [31:0]   lo_rdata;
    logic [1:0]    cap_off;
    logic [1:0]    cap_size;
    logic          cap_unsigned;
    logic          cap_write;

    // Accept-side decode.
    logic          accept;
    logic [2:0]    nbytes;
    logic [3:0]    be4;
    logic [1:0]    off;
    logic          crossing;
    logic [32:0]   last_byte;
    logic          acc_error;
    logic [7:0]    be8;
    logic [63:0]   wdata64;
    logic [WW-1:0] idx;

    // Single memory port, shared by the accept beat and the SPLIT beat.
    logic [WW-1:0] mem_idx;
    logic [31:0]   mem_rword;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   rd_single;
    logic [31:0]   rd_split;

    assign bus.req_ready  = ready;
    assign bus.resp_valid = rsp_valid;
    assign bus.resp_rdata = rsp_rdata;
    assign bus.resp_error = rsp_error;

    // Truncate assembled little-endian data to the access size and extend it.
    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [1:0]  size,
                                           input logic        uns);
        case (size)
            2'd0:    extend = {{24{~uns & raw[7]}},  raw[7:0]};
            2'd1:    extend = {{16{~uns & raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    assign accept = bus.req_valid && ready && !reset;
    assign off    = bus.req_addr[1:0];
    assign idx    = bus.req_addr[AW-1:2];

    // Access size to byte count and LSB-aligned lane mask.
    always_comb begin
        nbytes = 3'd4;
        be4    = 4'hF;
        case (bus.req_size)
            2'd0:    begin nbytes = 3'd1; be4 = 4'h1; end
            2'd1:    begin nbytes = 3'd2; be4 = 4'h3; end
            default: begin nbytes = 3'd4; be4 = 4'hF; end
        endcase
    end

    // Widened arithmetic so addresses near 2^32 cannot wrap into range.
    assign last_byte = {1'b0, bus.req_addr} + {30'd0, nbytes} - 33'd1;
    assign crossing  = ({1'b0, off} + nbytes) > 3'd4;
    assign acc_error = (bus.req_size == 2'd3)
                    || (last_byte >= 33'(DEPTH_BYTES))
                    || (!ALLOW_MISALIGNED && crossing);

    // Spread lanes across an 8-byte window: low half is this word, high half the next.
    assign be8     = {4'd0, be4} << off;
    assign wdata64 = {32'd0, bus.req_wdata} << {off, 3'b000};

    assign mem_idx   = (state == SPLIT) ? hi_idx   : idx;
    assign mem_rword = mem[mem_idx];
    assign mem_be    = (state == SPLIT) ? hi_be    : be8[3:0];
    assign mem_wdata = (state == SPLIT) ? hi_wdata : wdata64[31:0];
    assign mem_we    = (accept && bus.req_write && !acc_error)
                    || (state == SPLIT && cap_write && !reset);

    // Crossing accesses always have a non-zero offset, so the high shift is 8..24.
    assign rd_single = mem_rword >> {off, 3'b000};
    assign rd_split  = (lo_rdata >> {cap_off, 3'b000})
                     | (mem_rword << (6'd32 - {1'b0, cap_off, 3'b000}));

    // Byte-lane writes into the storage array; contents are never reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            ready        <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_error    <= 1'b0;
            hi_idx       <= '0;
            hi_be        <= 4'd0;
            hi_wdata     <= 32'd0;
            lo_rdata     <= 32'd0;
            cap_off      <= 2'd0;
            cap_size     <= 2'd0;
            cap_unsigned <= 1'b0;
            cap_write    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_off      <= off;
                        cap_size     <= bus.req_size;
                        cap_unsigned <= bus.req_unsigned;
                        cap_write    <= bus.req_write;
                        ready        <= 1'b0;
                        if (acc_error) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'd0;
                            rsp_error <= 1'b1;
                        end else if (crossing) begin
                            state    <= SPLIT;
                            hi_idx   <= idx + WW'(1);
                            hi_be    <= be8[7:4];
                            hi_wdata <= wdata64[63:32];
                            lo_rdata <= mem_rword;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b0;
                            rsp_rdata <= bus.req_write ? 32'd0
                                       : extend(rd_single, bus.req_size, bus.req_unsigned);
                        end
                    end
                end
                SPLIT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_error <= 1'b0;
                    rsp_rdata <= cap_write ? 32'd0
                               : extend(rd_split, cap_size, cap_unsigned);
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        ready     <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl: vector table with a
//               response scoreboard, plus hand-written back-pressure and
//               reset-during-split sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    typedef struct {
        bit          sel;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid0, valid1, wr, uns, resp_ready, sel;
    logic [31:0] addr, wdata;
    logic [1:0]  size;

    logic        out_ready, out_valid, out_err;
    logic [31:0] out_rdata;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[$];

    data_mem_ctrl_if bus0();
    data_mem_ctrl_if bus1();

    always #5 clock = ~clock;

    assign bus0.req_valid = valid0;  assign bus1.req_valid = valid1;
    assign bus0.req_write = wr;      assign bus1.req_write = wr;
    assign bus0.req_addr  = addr;    assign bus1.req_addr  = addr;
    assign bus0.req_size  = size;    assign bus1.req_size  = size;
    assign bus0.req_unsigned = uns;  assign bus1.req_unsigned = uns;
    assign bus0.req_wdata = wdata;   assign bus1.req_wdata = wdata;
    assign bus0.resp_ready = resp_ready;
    assign bus1.resp_ready = resp_ready;

    assign out_ready = sel ? bus1.req_ready  : bus0.req_ready;
    assign out_valid = sel ? bus1.resp_valid : bus0.resp_valid;
    assign out_rdata = sel ? bus1.resp_rdata : bus0.resp_rdata;
    assign out_err   = sel ? bus1.resp_error : bus0.resp_error;

    data_mem_ctrl #(.DEPTH_BYTES(1024), .ALLOW_MISALIGNED(1'b1)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    data_mem_ctrl #(.DEPTH_BYTES(64), .ALLOW_MISALIGNED(1'b0)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input bit s, input bit w, input logic [31:0] a,
                                input logic [1:0] sz, input bit u, input logic [31:0] wd,
                                input logic [31:0] er, input bit ee, input int el);
        vec_t v;
        v.sel = s; v.wr = w; v.addr = a; v.size = sz; v.uns = u; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    // Drive one request, push its expectation, then pop and compare when the response appears.
    task automatic run(input vec_t v);
        exp_t e;
        int   lat;
        sel = v.sel;
        @(negedge clock);
        wr = v.wr; addr = v.addr; size = v.size; uns = v.uns; wdata = v.wdata;
        if (v.sel) valid1 = 1'b1; else valid0 = 1'b1;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        sb.push_back(e);
        check($sformatf("req_ready_idle@%h", v.addr), 32'(out_ready), 32'd1);
        @(posedge clock); #1;
        valid0 = 1'b0; valid1 = 1'b0;
        // Scramble inputs after accept: the captured request must be unaffected.
        wr = 1'b0; addr = $urandom; size = 2'($urandom); uns = 1'($urandom); wdata = $urandom;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL resp_timeout@%h: got no response expected latency %0d", v.addr, e.lat);
        end else begin
            check($sformatf("rdata@%h", v.addr),   out_rdata, e.rdata);
            check($sformatf("error@%h", v.addr),   32'(out_err), 32'(e.err));
            check($sformatf("latency@%h", v.addr), 32'(lat), 32'(e.lat));
            check($sformatf("req_ready_busy@%h", v.addr), 32'(out_ready), 32'd0);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; resp_ready = 1'b1; sel = 1'b0;
        wr = 1'b0; addr = 32'd0; size = 2'd0; uns = 1'b0; wdata = 32'd0;

        // Vector table: sel, wr, addr, size, uns, wdata, exp_rdata, exp_err, exp_lat.
        tbl.push_back(mk(0, 1, 32'h10,  2, 0, 32'hDEADBEEF, 32'h0,        0, 1));
        tbl.push_back(mk(0, 0, 32'h10,  2, 0, 32'h0,        32'hDEADBEEF, 0, 1));
        tbl.push_back(mk(0, 0, 32'h13,  0, 0, 32'h0,        32'hFFFFFFDE, 0, 1));
        tbl.push_back(mk(0, 0, 32'h13,  0, 1, 32'h0,        32'h000000DE, 0, 1));
        tbl.push_back(mk(0, 0, 32'h12,  1, 0, 32'h0,        32'hFFFFDEAD, 0, 1));
        tbl.push_back(mk(0, 0, 32'h10,  1, 1, 32'h0,        32'h0000BEEF, 0, 1));
        tbl.push_back(mk(0, 1, 32'h11,  0, 0, 32'hAAAAAA55, 32'h0,        0, 1));
        tbl.push_back(mk(0, 0, 32'h10,  2, 0, 32'h0,        32'hDEAD55EF, 0, 1));
        tbl.push_back(mk(0, 1, 32'h1E,  2, 0, 32'h11223344, 32'h0,        0, 2));
        tbl.push_back(mk(0, 0, 32'h1E,  2, 0, 32'h0,        32'h11223344, 0, 2));
        tbl.push_back(mk(0, 0, 32'h1E,  0, 1, 32'h0,        32'h00000044, 0, 1));
        tbl.push_back(mk(0, 0, 32'h1F,  0, 1, 32'h0,        32'h00000033, 0, 1));
        tbl.push_back(mk(0, 0, 32'h20,  0, 1, 32'h0,        32'h00000022, 0, 1));
        tbl.push_back(mk(0, 0, 32'h21,  0, 1, 32'h0,        32'h00000011, 0, 1));
        tbl.push_back(mk(0, 0, 32'h1F,  1, 0, 32'h0,        32'h00002233, 0, 2));
        tbl.push_back(mk(0, 1, 32'h3FE, 1, 0, 32'h9999ABCD, 32'h0,        0, 1));
        tbl.push_back(mk(0, 1, 32'h3FE, 2, 0, 32'h12345678, 32'h0,        1, 1));
        tbl.push_back(mk(0, 0, 32'h3FE, 2, 0, 32'h0,        32'h0,        1, 1));
        tbl.push_back(mk(0, 0, 32'h3FE, 1, 1, 32'h0,        32'h0000ABCD, 0, 1));
        tbl.push_back(mk(0, 0, 32'h3FF, 0, 0, 32'h0,        32'hFFFFFFAB, 0, 1));
        tbl.push_back(mk(0, 0, 32'h400, 0, 1, 32'h0,        32'h0,        1, 1));
        tbl.push_back(mk(0, 1, 32'h10,  3, 0, 32'h0,        32'h0,        1, 1));
        tbl.push_back(mk(0, 0, 32'h10,  2, 0, 32'h0,        32'hDEAD55EF, 0, 1));
        tbl.push_back(mk(1, 1, 32'h08,  2, 0, 32'h01020304, 32'h0,        0, 1));
        tbl.push_back(mk(1, 1, 32'h06,  2, 0, 32'hFFFFFFFF, 32'h0,        1, 1));
        tbl.push_back(mk(1, 0, 32'h08,  2, 0, 32'h0,        32'h01020304, 0, 1));
        tbl.push_back(mk(1, 0, 32'h07,  1, 0, 32'h0,        32'h0,        1, 1));
        tbl.push_back(mk(1, 0, 32'h09,  1, 1, 32'h0,        32'h00000203, 0, 1));
        tbl.push_back(mk(1, 0, 32'h3E,  2, 0, 32'h0,        32'h0,        1, 1));

        // Reset state of both instances.
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready0",  32'(bus0.req_ready),  32'd1);
        check("rst_resp_valid0", 32'(bus0.resp_valid), 32'd0);
        check("rst_rdata0",      bus0.resp_rdata,      32'd0);
        check("rst_error0",      32'(bus0.resp_error), 32'd0);
        check("rst_req_ready1",  32'(bus1.req_ready),  32'd1);
        check("rst_resp_valid1", 32'(bus1.resp_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) run(tbl[i]);

        // Back-pressure: response must hold for 5 cycles with resp_ready low.
        sel = 1'b0;
        @(negedge clock);
        resp_ready = 1'b0;
        wr = 1'b0; addr = 32'h10; size = 2'd2; uns = 1'b0; valid0 = 1'b1;
        @(posedge clock); #1;
        valid0 = 1'b0; addr = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            check($sformatf("hold_valid%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("hold_rdata%0d", c), out_rdata, 32'hDEAD55EF);
            check($sformatf("hold_ready%0d", c), 32'(out_ready), 32'd0);
        end
        @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock); #1;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_ready", 32'(out_ready), 32'd1);

        // Reset while in SPLIT: low beat stays written, high beat is dropped.
        run(mk(0, 1, 32'h2C, 2, 0, 32'h00000000, 32'h0, 0, 1));
        run(mk(0, 1, 32'h30, 2, 0, 32'h00000000, 32'h0, 0, 1));
        sel = 1'b0;
        @(negedge clock);
        wr = 1'b1; addr = 32'h2E; size = 2'd2; uns = 1'b0; wdata = 32'hAABBCCDD; valid0 = 1'b1;
        @(posedge clock); #1;
        valid0 = 1'b0;
        check("split_no_valid", 32'(out_valid), 32'd0);
        check("split_ready",    32'(out_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("split_rst_valid", 32'(out_valid), 32'd0);
        check("split_rst_ready", 32'(out_ready), 32'd1);
        check("split_rst_error", 32'(out_err),   32'd0);
        @(negedge clock);
        reset = 1'b0;
        run(mk(0, 0, 32'h30, 2, 0, 32'h0, 32'h00000000, 0, 1));
        run(mk(0, 0, 32'h2C, 2, 0, 32'h0, 32'hCCDD0000, 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
